// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache bank miss controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_DATA,
    FILL_REQ,
    FILL_DATA,
    UPDATE,
    RESP
  } state_e;

  localparam int unsigned DEF_TAG_BITS = 20;
  localparam int unsigned DEF_IDX_BITS = 10;

  typedef logic [DEF_TAG_BITS+DEF_IDX_BITS-1:0] line_addr_t;

  // A one-way or one-word configuration still needs a 1-bit field.
  function automatic int unsigned way_w(input int unsigned assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

  function automatic int unsigned beat_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_line_beat_counter.sv
// Word-within-line counter shared by the writeback and refill data phases.
module line_beat_counter #(
  parameter int unsigned line_words = 4,
  parameter int unsigned BEAT_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              enable,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  logic [BEAT_W-1:0] beat_q;

  assign beat = beat_q;
  assign last = (beat_q == BEAT_W'(line_words - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      beat_q <= '0;
    end else if (enable) begin
      beat_q <= last ? '0 : beat_q + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencing controller for one set-associative cache bank: lookup,
// optional dirty-victim writeback, line refill, array/LRU update, response.
//
// state     | meaning
// IDLE      | ready for a CPU request
// LOOKUP    | arrays read, tag compare result sampled
// WB_REQ    | writeback command pending on memory port
// WB_DATA   | streaming victim words to memory
// FILL_REQ  | refill command pending on memory port
// FILL_DATA | writing returned words into the victim way
// UPDATE    | tag/dirty/LRU/store commit
// RESP      | one-cycle response to the CPU
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned associativity = 4,
  parameter int unsigned idx_bits      = 10,
  parameter int unsigned tag_bits      = 20,
  parameter int unsigned line_words    = 4,
  localparam int unsigned WAY_W        = way_w(associativity),
  localparam int unsigned BEAT_W       = beat_w(line_words)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [idx_bits-1:0]          req_idx_i,
  input  logic [tag_bits-1:0]          req_tag_i,
  input  logic                         hit_i,
  input  logic [WAY_W-1:0]             hit_way_i,
  input  logic [WAY_W-1:0]             victim_way_i,
  input  logic                         victim_dirty_i,
  input  logic [tag_bits-1:0]          victim_tag_i,
  output logic [idx_bits-1:0]          arr_idx_o,
  output logic [WAY_W-1:0]             arr_way_o,
  output logic [BEAT_W-1:0]            arr_beat_o,
  output logic                         arr_rd_o,
  output logic                         arr_fill_we_o,
  output logic                         tag_we_o,
  output logic                         cpu_wr_o,
  output logic                         lru_touch_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic                         mem_we_o,
  output logic [tag_bits+idx_bits-1:0] mem_addr_o,
  output logic                         mem_wbeat_valid_o,
  input  logic                         mem_wbeat_ready_i,
  input  logic                         mem_rbeat_valid_i,
  output logic                         resp_valid_o,
  output logic                         resp_miss_o
);

  state_e state_q, state_d;

  logic                we_q;
  logic                miss_q;
  logic [idx_bits-1:0] idx_q;
  logic [tag_bits-1:0] tag_q;
  logic [tag_bits-1:0] vtag_q;
  logic [WAY_W-1:0]    way_q;

  logic              beat_en;
  logic              beat_clr;
  logic              beat_last;
  logic [BEAT_W-1:0] beat;

  line_beat_counter #(
    .line_words(line_words),
    .BEAT_W    (BEAT_W)
  ) u_beat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (beat_clr),
    .enable(beat_en),
    .beat  (beat),
    .last  (beat_last)
  );

  assign arr_idx_o  = idx_q;
  assign arr_way_o  = way_q;
  assign arr_beat_o = beat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      miss_q  <= 1'b0;
      idx_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        we_q   <= req_we_i;
        idx_q  <= req_idx_i;
        tag_q  <= req_tag_i;
        miss_q <= 1'b0;
      end
      // Hit way and victim way share one register; arr_way_o follows it.
      if (state_q == LOOKUP) begin
        if (hit_i) begin
          way_q  <= hit_way_i;
          miss_q <= 1'b0;
        end else begin
          way_q  <= victim_way_i;
          vtag_q <= victim_tag_i;
          miss_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    req_ready_o       = 1'b0;
    arr_rd_o          = 1'b0;
    arr_fill_we_o     = 1'b0;
    tag_we_o          = 1'b0;
    cpu_wr_o          = 1'b0;
    lru_touch_o       = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_we_o          = 1'b0;
    mem_addr_o        = '0;
    mem_wbeat_valid_o = 1'b0;
    resp_valid_o      = 1'b0;
    resp_miss_o       = 1'b0;
    beat_en           = 1'b0;
    beat_clr          = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        arr_rd_o = 1'b1;
        if (hit_i)               state_d = UPDATE;
        else if (victim_dirty_i) state_d = WB_REQ;
        else                     state_d = FILL_REQ;
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = {vtag_q, idx_q};
        if (mem_req_ready_i) begin
          beat_clr = 1'b1;
          state_d  = WB_DATA;
        end
      end
      WB_DATA: begin
        arr_rd_o          = 1'b1;
        mem_wbeat_valid_o = 1'b1;
        if (mem_wbeat_ready_i) begin
          beat_en = 1'b1;
          if (beat_last) state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {tag_q, idx_q};
        if (mem_req_ready_i) begin
          beat_clr = 1'b1;
          state_d  = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (mem_rbeat_valid_i) begin
          arr_fill_we_o = 1'b1;
          beat_en       = 1'b1;
          if (beat_last) state_d = UPDATE;
        end
      end
      UPDATE: begin
        lru_touch_o = 1'b1;
        tag_we_o    = miss_q;
        cpu_wr_o    = we_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_miss_o  = miss_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
